// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a single-cycle 32-bit ALU
// with a one-entry registered result slot that can refill while it drains.
module alu_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_C
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;
  localparam logic [OP_W-1:0] OP_SRA = 3'b101;

  logic [0:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_c_q, resp_c_d;

  logic              free_c;
  logic              gnt0_c, gnt1_c;
  logic [DATA_W-1:0] op_a_c, op_b_c;
  logic [OP_W-1:0]   op_c;

  // Shift amounts of 32 or more saturate: zero fill, or sign fill for SRA.
  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [OP_W-1:0]   op);
    logic big;
    big = |b[DATA_W-1:5];
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_SRL:  alu_f = big ? '0 : (a >> b[4:0]);
      OP_SRA:  alu_f = big ? {DATA_W{a[DATA_W-1]}} : DATA_W'($signed(a) >>> b[4:0]);
      default: alu_f = '0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    resp_id_d = resp_id_q;
    resp_c_d  = resp_c_q;

    free_c = (state_q == ST_EMPTY) | resp_ready;
    gnt0_c = rst_n & free_c & req0_valid & (~req1_valid | (prio_q == 1'b0));
    gnt1_c = rst_n & free_c & req1_valid & (~req0_valid | (prio_q == 1'b1));

    op_a_c = gnt1_c ? req1_A  : req0_A;
    op_b_c = gnt1_c ? req1_B  : req0_B;
    op_c   = gnt1_c ? req1_op : req0_op;

    // A grant overwrites the slot even while it drains, so no bubble appears.
    if (gnt0_c | gnt1_c) begin
      state_d   = ST_FULL;
      resp_c_d  = alu_f(op_a_c, op_b_c, op_c);
      resp_id_d = gnt1_c;
      prio_d    = ~gnt1_c;
    end else if (resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      prio_q    <= 1'b0;
      resp_id_q <= 1'b0;
      resp_c_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      resp_id_q <= resp_id_d;
      resp_c_q  <= resp_c_d;
    end
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;
  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = resp_id_q;
  assign resp_C     = resp_c_q;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and result slot.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_A, req0_B;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_A, req1_B;
  logic [2:0]  req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_C;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic        m_valid = 1'b0;
  logic        m_id    = 1'b0;
  logic [31:0] m_c     = 32'h0;
  logic        m_prio  = 1'b0;
  logic        e_g0, e_g1;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_C(resp_C)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa;
    int     sh;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (b > 32'd31) ? 32'h0 : (a >> b);
      3'd5: begin
        sa = longint'($signed(a));
        sh = (b > 32'd63) ? 63 : int'(b);
        return 32'(sa >>> sh);
      end
      default: return 32'h0;
    endcase
  endfunction

  // Apply inputs for this cycle and predict which requester is accepted.
  task automatic drive(input logic rstn,
                       input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                       input logic rr);
    logic free;
    rst_n = rstn; resp_ready = rr;
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_op = op0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_op = op1;
    free = !m_valid || rr;
    e_g0 = 1'b0; e_g1 = 1'b0;
    if (rstn && free) begin
      if (v0 && v1) begin
        if (m_prio) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else begin
        e_g0 = v0; e_g1 = v1;
      end
    end
    #1;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 1'b0; m_c = 32'h0; m_prio = 1'b0;
    end else if (e_g0) begin
      m_c = ref_alu(req0_A, req0_B, req0_op); m_id = 1'b0; m_valid = 1'b1; m_prio = 1'b1;
    end else if (e_g1) begin
      m_c = ref_alu(req1_A, req1_B, req1_op); m_id = 1'b1; m_valid = 1'b1; m_prio = 1'b0;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'd1, 32'd2, 3'd0, 1'b1, 32'd3, 32'd4, 3'd0, 1'b1);
      n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy0 got=%b exp=0", req0_ready); end
      n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy1 got=%b exp=0", req1_ready); end
      tick();
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
      n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id got=%b exp=0", resp_id); end
      n_checks++; if (resp_C !== 32'h0) begin n_fail++; $display("FAIL reset_c got=%h exp=0", resp_C); end
    end
  endtask

  task automatic test_single_add();
    drive(1'b1, 1'b1, 32'd5, 32'd3, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_rdy0 got=%b exp=1", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL add_rdy1 got=%b exp=0", req1_ready); end
    tick();
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b exp=1", resp_valid); end
    n_checks++; if (resp_C !== 32'd8) begin n_fail++; $display("FAIL add_c got=%h exp=8", resp_C); end
    n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL add_id got=%b exp=0", resp_id); end
    drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    tick();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", resp_valid); end
  endtask

  task automatic test_contention();
    logic        k;
    logic [31:0] exp_c;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      k = 1'(i % 2);
      exp_c = k ? 32'h30 : 32'hFFFF_FFFF;
      drive(1'b1, 1'b1, 32'd1, 32'd2, 3'd1, 1'b1, 32'hF0, 32'h3C, 3'd2, 1'b1);
      n_checks++; if (req0_ready !== !k) begin n_fail++; $display("FAIL cont_rdy0[%0d] got=%b exp=%b", i, req0_ready, !k); end
      n_checks++; if (req1_ready !== k) begin n_fail++; $display("FAIL cont_rdy1[%0d] got=%b exp=%b", i, req1_ready, k); end
      tick();
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid[%0d] got=%b exp=1", i, resp_valid); end
      n_checks++; if (resp_id !== k) begin n_fail++; $display("FAIL cont_id[%0d] got=%b exp=%b", i, resp_id, k); end
      n_checks++; if (resp_C !== exp_c) begin n_fail++; $display("FAIL cont_c[%0d] got=%h exp=%h", i, resp_C, exp_c); end
    end
  endtask

  task automatic test_backpressure();
    // Prio is 0 after an even number of alternating grants; req0 takes it, prio -> 1.
    drive(1'b1, 1'b1, 32'd7, 32'd1, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h10, 32'h01, 3'd3, 1'b0);
      n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rdy0[%0d] got=%b exp=0", i, req0_ready); end
      n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rdy1[%0d] got=%b exp=0", i, req1_ready); end
      tick();
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); end
      n_checks++; if (resp_C !== 32'd8) begin n_fail++; $display("FAIL bp_c[%0d] got=%h exp=8", i, resp_C); end
      n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL bp_id[%0d] got=%b exp=0", i, resp_id); end
    end
    // Both valid on release: an unchanged prio of 1 must pick requester 1.
    drive(1'b1, 1'b1, 32'd9, 32'd9, 3'd0, 1'b1, 32'h10, 32'h01, 3'd3, 1'b1);
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_rdy1 got=%b exp=1", req1_ready); end
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rel_rdy0 got=%b exp=0", req0_ready); end
    tick();
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rel_valid got=%b exp=1", resp_valid); end
    n_checks++; if (resp_C !== 32'h11) begin n_fail++; $display("FAIL bp_rel_c got=%h exp=11", resp_C); end
    n_checks++; if (resp_id !== 1'b1) begin n_fail++; $display("FAIL bp_rel_id got=%b exp=1", resp_id); end
  endtask

  task automatic test_shift_boundaries();
    logic [31:0] a_t [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h7000_0000};
    logic [31:0] b_t [5] = '{32'd4, 32'd40, 32'd32, 32'd1, 32'd40};
    logic [2:0]  o_t [5] = '{3'd5, 3'd5, 3'd4, 3'd6, 3'd5};
    logic [31:0] e_t [5] = '{32'hF800_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, a_t[i], b_t[i], o_t[i], 1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
      tick();
      n_checks++; if (resp_C !== e_t[i]) begin n_fail++; $display("FAIL shift[%0d] got=%h exp=%h", i, resp_C, e_t[i]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'd2, 32'd3, 3'd0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'd4, 32'd4, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_rdy0 got=%b exp=0", req0_ready); end
    tick();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_C !== 32'h0) begin n_fail++; $display("FAIL rmid_c got=%h exp=0", resp_C); end
    drive(1'b1, 1'b1, 32'd4, 32'd4, 3'd0, 1'b1, 32'd1, 32'd1, 3'd0, 1'b1);
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_post_rdy0 got=%b exp=1", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_post_rdy1 got=%b exp=0", req1_ready); end
    tick();
    n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_post_id got=%b exp=0", resp_id); end
    n_checks++; if (resp_C !== 32'd8) begin n_fail++; $display("FAIL rmid_post_c got=%h exp=8", resp_C); end
  endtask

  task automatic test_random();
    logic [31:0] a0, b0, a1, b1;
    for (int i = 0; i < 400; i++) begin
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
      b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
      drive(($urandom_range(0, 59) != 0),
            1'($urandom_range(0, 1)), a0, b0, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), a1, b1, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7));
      n_checks++; if (req0_ready !== e_g0) begin n_fail++; $display("FAIL rnd_rdy0[%0d] got=%b exp=%b", i, req0_ready, e_g0); end
      n_checks++; if (req1_ready !== e_g1) begin n_fail++; $display("FAIL rnd_rdy1[%0d] got=%b exp=%b", i, req1_ready, e_g1); end
      tick();
      n_checks++; if (resp_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, resp_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (resp_id !== m_id) begin n_fail++; $display("FAIL rnd_id[%0d] got=%b exp=%b", i, resp_id, m_id); end
        n_checks++; if (resp_C !== m_c) begin n_fail++; $display("FAIL rnd_c[%0d] got=%h exp=%h", i, resp_C, m_c); end
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_shift_boundaries();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: none; the block is fixed at two requesters, 32-bit operands and a 3-bit opcode.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 req0_valid  input  1  requester 0 presents an operation.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-007 req0_A, req0_B  input  32 each  requester 0 operands.
REQ-008 req0_op  input  3  requester 0 ALU opcode.
REQ-009 req1_valid, req1_ready, req1_A, req1_B, req1_op: same widths and meanings as the requester 0 ports, for requester 1.
REQ-010 resp_valid  output  1  result register holds an undelivered result.
REQ-011 resp_ready  input  1  consumer takes the result this cycle when high together with resp_valid.
REQ-012 resp_id  output  1  index of the requester that owns the result.
REQ-013 resp_C  output  32  result value.

Function
REQ-014 Opcode map: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 logical right shift A>>B; 101 arithmetic right shift of A by B; 110 and 111 produce 32'h0.
- Add and subtract wrap modulo 2^32.
REQ-015 Shifts use the full 32-bit B.
- B>=32 with op 100 gives 0.
- B>=32 with op 101 gives 32'hFFFFFFFF if A[31]=1, otherwise 0.
REQ-016 Output register state: EMPTY (resp_valid=0) or FULL (resp_valid=1).
REQ-017 Slot-free condition: free = !resp_valid | resp_ready. This lets a new result enter in the same cycle the old one drains.
REQ-018 Arbitration is round-robin with a 1-bit priority pointer prio. prio=k means requester k wins when both are valid.
REQ-019 Grant logic (combinational):
- gnt0 = free & req0_valid & (!req1_valid | prio==0).
- gnt1 = free & req1_valid & (!req0_valid | prio==1).
- req0_ready = gnt0 and req1_ready = gnt1.
- At most one grant is active per cycle.
REQ-020 On a grant to requester k at edge N:
- resp_C and resp_id=k are loaded and resp_valid=1 from edge N.
- Latency is exactly 1 cycle from acceptance to resp_valid.
REQ-021 After every grant, prio becomes the other requester (prio <= !k). With no grant, prio holds.
REQ-022 If the slot is FULL and resp_ready=0:
- both readies are 0;
- resp_C, resp_id and resp_valid hold stable;
- prio holds.
REQ-023 If resp_valid & resp_ready and there is no grant, resp_valid becomes 0 at the next edge. resp_C and resp_id may hold their old values.
REQ-024 Simultaneous drain and grant: the new result replaces the old one with no bubble, and resp_valid stays 1.
REQ-025 Throughput: one operation per cycle while resp_ready=1.
REQ-026 Operands and op are sampled only in the grant cycle. Requester inputs may change freely when not granted.
REQ-027 readies do not depend on their own req_valid's acceptance combinationally looping through resp_ready. resp_ready reaches the readies by one combinational path only.

Reset
REQ-028 When rst_n=0 at a rising edge, the next state is: resp_valid=0, resp_id=0, resp_C=32'h0, prio=0.
REQ-029 During reset cycles both readies are 0, regardless of the valids.
REQ-030 A result held when reset asserts is discarded. A request presented during reset is not accepted.

Verification
REQ-031 Single add: reset, then req0 {A=5, B=3, op=000}, resp_ready=1 -> req0_ready=1 in cycle N; resp_valid=1, resp_C=8, resp_id=0 in cycle N+1.
REQ-032 Contention: both valid every cycle, req0 op=001 A=1 B=2, req1 op=010 A=32'hF0 B=32'h3C, resp_ready=1 -> grants alternate 0,1,0,1; results alternate 32'hFFFFFFFF (id 0) and 32'h30 (id 1).
REQ-033 Backpressure: one result FULL, resp_ready=0 for 3 cycles with req1_valid=1 -> both readies 0; resp_C stable; prio unchanged. When resp_ready rises, req1 is granted in that same cycle and the new result is visible the next cycle with no bubble.
REQ-034 Shift boundaries:
- op=101 A=32'h80000000 B=4 -> 32'hF8000000.
- op=101 same A, B=40 -> 32'hFFFFFFFF.
- op=100 A=32'h80000000 B=32 -> 0.
- op=110 -> 0.
REQ-035 Reset mid-operation: resp FULL with resp_ready=0, then rst_n=0 for 1 cycle with req0_valid=1 -> after the edge resp_valid=0, req0_ready=0 during reset, prio=0. On the first cycle after reset with both valid, requester 0 is granted.
